su_cfg_loader: RTL

Serial configuration loader for a row of switch units in the routing fabric. It accepts a bit-serial configuration stream under a valid/ready handshake into a shadow register and checks even parity over the frame. Only on a good frame does it commit the whole image to the `dir_con` buses that drive the switch units' transmission gates. Switch settings therefore never change mid-load or after a corrupted load.

---
 rtl/su_cfg_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/su_cfg_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// su_cfg_loader : serial, parity-checked configuration loader for switch units
// Revision 1.0  : initial release
// ---------------------------------------------------------------------------
module su_cfg_loader #(
  parameter int NUM_SU = 8,
  parameter int CFG_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    cfg_valid_i,
  input  logic                    cfg_bit_i,
  output logic                    cfg_ready_o,
  output logic [NUM_SU*CFG_W-1:0] dir_con_bus_o,
  output logic                    busy_o,
  output logic                    cfg_done_o,
  output logic                    cfg_err_o
);

  localparam int TOTAL = NUM_SU * CFG_W;
  localparam int CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TOTAL-1:0]   shadow_q, shadow_d;
  logic [TOTAL-1:0]   dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               par_q, par_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      dir_q    <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    done_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          par_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        // Abort takes priority over a bit offered in the same cycle.
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (cfg_valid_i) begin
          par_d = par_q ^ cfg_bit_i;
          if (cnt_q == CNT_W'(TOTAL)) begin
            state_d = ST_CHECK;
          end else begin
            shadow_d = {cfg_bit_i, shadow_q[TOTAL-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_CHECK: begin
        if (!par_q) begin
          dir_d   = shadow_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (start_i) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          par_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cfg_ready_o   = (state_q == ST_LOAD);
  assign busy_o        = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign dir_con_bus_o = dir_q;
  assign cfg_done_o    = done_q;
  assign cfg_err_o     = err_q;

endmodule
`default_nettype wire
